// File: rtl/frame_transmitter_if.sv
// Parallel-side handshake and serial outputs of the frame transmitter.
// The sender uses the master modport; the transmitter itself uses slave.
interface frame_transmitter_if #(
  parameter int DATA_LEN = 8
);
  logic [DATA_LEN-1:0] din;
  logic                tx_valid;
  logic                tx_ready;
  logic                tx;
  logic                busy;
  logic                tx_done;

  modport master (
    output din,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  din,
    input  tx_valid,
    output tx_ready,
    output tx,
    output busy,
    output tx_done
  );
endinterface

// File: rtl/frame_transmitter.sv
// Serial frame transmitter: SFD then data word, LSB first, one bit per clk.
// Define FRAME_TX_GAP_EN to force GAP_LEN idle cycles after every frame.
module frame_transmitter #(
  parameter int                 DATA_LEN = 8,
  parameter int                 SFD_LEN  = 8,
  parameter logic [SFD_LEN-1:0] SFD      = 8'b11010101,
  parameter int                 GAP_LEN  = 4
) (
  input  logic          clk,
  input  logic          reset,
  frame_transmitter_if.slave bus
);

  localparam logic [15:0] SFD_LAST  = 16'(SFD_LEN - 1);
  localparam logic [15:0] DATA_LAST = 16'(DATA_LEN - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_LEN - 1);

`ifdef FRAME_TX_GAP_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SFD  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SFD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  logic unused_gap;
  assign unused_gap = ^GAP_LAST;
`endif

  state_t              state, state_next;
  logic [15:0]         cnt, cnt_next;
  logic [DATA_LEN-1:0] data_q, data_src;
  logic [SFD_LEN-1:0]  sfd_shifted;
  logic [DATA_LEN-1:0] data_shifted;
  logic                load;
  logic                tx_q, tx_next;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (bus.tx_valid) begin
          load       = 1'b1;
          state_next = S_SFD;
        end
      end
      S_SFD: begin
        if (cnt == SFD_LAST) begin
          state_next = S_DATA;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == DATA_LAST) begin
`ifdef FRAME_TX_GAP_EN
          state_next = S_GAP;
`else
          state_next = S_IDLE;
`endif
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
`ifdef FRAME_TX_GAP_EN
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
`endif
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // tx is registered, so it is computed from where the FSM is about to be.
  always_comb begin
    data_src     = load ? bus.din : data_q;
    sfd_shifted  = SFD >> cnt_next;
    data_shifted = data_src >> cnt_next;
    tx_next      = 1'b0;
    case (state_next)
      S_SFD:   tx_next = sfd_shifted[0];
      S_DATA:  tx_next = data_shifted[0];
      default: tx_next = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      tx_q  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      tx_q  <= tx_next;
    end
  end

  // NOTE: the data register is not reset; it is always loaded on acceptance
  // before any bit of it reaches the line.
  always_ff @(posedge clk) begin
    if (load) data_q <= bus.din;
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = (state == S_IDLE);
  assign bus.busy     = (state == S_SFD) || (state == S_DATA);
  assign bus.tx_done  = (state == S_DATA) && (cnt == DATA_LAST);

endmodule
